// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_pkg
// Purpose  : Shared constants and types for the RAM data-port arbiter:
//            simulation MMIO addresses, requester index encoding, bus types.
// Revision : 1.0 - initial release
// ============================================================================
package ram_port_arbiter_pkg;

  // Simulation MMIO byte addresses (full 32-bit compare)
  localparam logic [31:0] CHAR_OUT_ADDR_DEF = 32'h0002_0000;
  localparam logic [31:0] SIM_CTRL_ADDR_DEF = 32'h0002_0002;

  // Requester index: also the value held in the last-grant register
  typedef enum logic {
    REQ_LSU = 1'b0,
    REQ_DBG = 1'b1
  } req_idx_e;

  // Data bus and strobe types shared with the RAM model
  typedef logic [31:0] data_bus_t;
  typedef logic [3:0]  byte_sel_t;

endpackage : ram_port_arbiter_pkg
`default_nettype wire

// File: rtl/ram_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_rr_arb2
// Purpose  : Two-way round-robin arbiter with a last-grant register.
//            Grant is combinational; on a tie the requester that did not
//            win last time is chosen. Resets so that requester 0 wins first.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter_rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_idx_e last_q;
  req_idx_e last_d;

  // Grant decision and next last-grant value
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == REQ_LSU) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    if (gnt_o != 2'b00) begin
      last_d = req_idx_e'(gnt_o[1]);
    end
  end

  // Last-grant register; reset value makes requester 0 win the first tie
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= REQ_DBG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : ram_port_arbiter_rr_arb2
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares the RAM data port between the LSU (m0) and the debug /
//            loader master (m1). One grant per cycle, registered response one
//            cycle later, and decode of the simulation MMIO registers
//            (character output, simulation halt) which never reach the RAM.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int          MEM_WORDS_LOG2 = 16,
  parameter logic [31:0] CHAR_OUT_ADDR  = CHAR_OUT_ADDR_DEF,
  parameter logic [31:0] SIM_CTRL_ADDR  = SIM_CTRL_ADDR_DEF
) (
  input  logic      clk_i,
  input  logic      rst_i,
  // requester 0 (LSU)
  input  logic      m0_req_i,
  input  logic      m0_we_i,
  input  data_bus_t m0_addr_i,
  input  byte_sel_t m0_sel_i,
  input  data_bus_t m0_wdata_i,
  output logic      m0_gnt_o,
  output logic      m0_rvalid_o,
  output data_bus_t m0_rdata_o,
  output logic      m0_err_o,
  // requester 1 (debug / loader)
  input  logic      m1_req_i,
  input  logic      m1_we_i,
  input  data_bus_t m1_addr_i,
  input  byte_sel_t m1_sel_i,
  input  data_bus_t m1_wdata_i,
  output logic      m1_gnt_o,
  output logic      m1_rvalid_o,
  output data_bus_t m1_rdata_o,
  output logic      m1_err_o,
  // RAM data port
  output logic      ram_ce_o,
  output logic      ram_we_o,
  output data_bus_t ram_addr_o,
  output byte_sel_t ram_sel_o,
  output data_bus_t ram_wdata_o,
  input  data_bus_t ram_rdata_i,
  // simulation MMIO
  output logic      char_valid_o,
  output logic [7:0] char_o,
  output logic      sim_halt_o
);

  logic [1:0] w_gnt;
  logic       w_any;
  logic       w_we;
  data_bus_t  w_addr;
  byte_sel_t  w_sel;
  data_bus_t  w_wdata;
  logic       w_is_char;
  logic       w_is_ctrl;
  logic       w_is_mmio;
  logic       w_in_range;
  logic       w_ram_hit;

  logic [1:0] rvalid_q, rvalid_d;
  logic [1:0] err_q, err_d;
  data_bus_t  rdata_q [2];
  data_bus_t  rdata_d [2];
  logic       char_valid_q, char_valid_d;
  logic [7:0] char_q, char_d;
  logic       halt_q, halt_d;

  ram_port_arbiter_rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i ({m1_req_i, m0_req_i}),
    .gnt_o (w_gnt)
  );

  assign m0_gnt_o = w_gnt[REQ_LSU];
  assign m1_gnt_o = w_gnt[REQ_DBG];
  assign w_any    = |w_gnt;

  // Winner mux and address decode; MMIO is checked before the RAM range
  always_comb begin
    w_we       = w_gnt[REQ_DBG] ? m1_we_i    : m0_we_i;
    w_addr     = w_gnt[REQ_DBG] ? m1_addr_i  : m0_addr_i;
    w_sel      = w_gnt[REQ_DBG] ? m1_sel_i   : m0_sel_i;
    w_wdata    = w_gnt[REQ_DBG] ? m1_wdata_i : m0_wdata_i;
    w_is_char  = (w_addr == CHAR_OUT_ADDR);
    w_is_ctrl  = (w_addr == SIM_CTRL_ADDR);
    w_is_mmio  = w_is_char | w_is_ctrl;
    w_in_range = ((w_addr >> (MEM_WORDS_LOG2 + 2)) == '0);
    w_ram_hit  = w_any & w_in_range & ~w_is_mmio;
  end

  // RAM port is driven only for in-range, non-MMIO grants; zero otherwise
  always_comb begin
    ram_ce_o    = w_ram_hit;
    ram_we_o    = w_ram_hit & w_we;
    ram_addr_o  = w_ram_hit ? w_addr  : '0;
    ram_sel_o   = w_ram_hit ? w_sel   : '0;
    ram_wdata_o = w_ram_hit ? w_wdata : '0;
  end

  // Next-state for the response slot and MMIO side effects
  always_comb begin
    char_d       = char_q;
    halt_d       = halt_q;
    char_valid_d = w_any & w_we & w_is_char & w_sel[0];
    if (char_valid_d) begin
      char_d = w_wdata[7:0];
    end
    if (w_any & w_we & w_is_ctrl & w_wdata[0]) begin
      halt_d = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      rvalid_d[i] = w_gnt[i] & ~w_we;
      err_d[i]    = w_gnt[i] & ~w_in_range & ~w_is_mmio;
      rdata_d[i]  = (w_gnt[i] & ~w_we & w_ram_hit) ? ram_rdata_i : '0;
    end
  end

  // Response and MMIO registers; reset discards any pending response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q     <= '0;
      err_q        <= '0;
      rdata_q[0]   <= '0;
      rdata_q[1]   <= '0;
      char_valid_q <= 1'b0;
      char_q       <= '0;
      halt_q       <= 1'b0;
    end else begin
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      rdata_q[0]   <= rdata_d[0];
      rdata_q[1]   <= rdata_d[1];
      char_valid_q <= char_valid_d;
      char_q       <= char_d;
      halt_q       <= halt_d;
    end
  end

  assign m0_rvalid_o  = rvalid_q[REQ_LSU];
  assign m1_rvalid_o  = rvalid_q[REQ_DBG];
  assign m0_err_o     = err_q[REQ_LSU];
  assign m1_err_o     = err_q[REQ_DBG];
  assign m0_rdata_o   = rdata_q[0];
  assign m1_rdata_o   = rdata_q[1];
  assign char_valid_o = char_valid_q;
  assign char_o       = char_q;
  assign sim_halt_o   = halt_q;

endmodule : ram_port_arbiter
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Self-checking bench for ram_port_arbiter: per-cycle vector table
//            plus a round-robin streaming sequence, with a small RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_sel = 0, m1_sel = 0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;
  logic        char_valid, sim_halt;
  logic [7:0]  char_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.MEM_WORDS_LOG2(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_sel_i(m0_sel),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_sel_i(m1_sel),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_sel_o(ram_sel), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .char_valid_o(char_valid), .char_o(char_out), .sim_halt_o(sim_halt)
  );

  // Small RAM model: 256 words, combinational read, byte-enabled write
  logic [31:0] mem [256];
  initial for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 | k;
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  typedef struct {
    logic        rst;
    logic        r0, w0; logic [31:0] a0; logic [3:0] s0; logic [31:0] d0;
    logic        r1, w1; logic [31:0] a1; logic [3:0] s1; logic [31:0] d1;
    logic [3:0]  e_ctl;  // {m0_gnt, m1_gnt, ram_ce, ram_we}
    logic [3:0]  e_sel;  // ram_sel
    logic [5:0]  e_rsp;  // {m0_rvalid, m1_rvalid, m0_err, m1_err, char_valid, sim_halt}
    logic [7:0]  e_ch;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_sel = v.s0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_sel = v.s1; m1_wdata = v.d1;
  endtask

  initial begin
    // rst, m0{req,we,addr,sel,wdata}, m1{...}, ctl, sel, rsp, ch, rd0, rd1
    // reset, then m0 write 0x10 / read back
    vq.push_back('{1, 0,0,32'h0,4'h0,32'h0, 0,0,32'h0,4'h0,32'h0, 4'b0000,4'h0,6'b000000,8'h00,32'h0,32'h0});
    vq.push_back('{0, 1,1,32'h10,4'hF,32'hDEADBEEF, 0,0,32'h0,4'h0,32'h0, 4'b1011,4'hF,6'b000000,8'h00,32'h0,32'h0});
    vq.push_back('{0, 1,0,32'h10,4'hF,32'h0, 0,0,32'h0,4'h0,32'h0, 4'b1010,4'hF,6'b000000,8'h00,32'h0,32'h0});
    vq.push_back('{0, 0,0,32'h0,4'h0,32'h0, 0,0,32'h0,4'h0,32'h0, 4'b0000,4'h0,6'b100000,8'h00,32'hDEADBEEF,32'h0});
    // tie: last grant was m0, so m1 first, then alternate
    vq.push_back('{0, 1,0,32'h20,4'hF,32'h0, 1,0,32'h24,4'hF,32'h0, 4'b0110,4'hF,6'b000000,8'h00,32'h0,32'h0});
    vq.push_back('{0, 1,0,32'h20,4'hF,32'h0, 1,0,32'h24,4'hF,32'h0, 4'b1010,4'hF,6'b010000,8'h00,32'h0,32'h10000009});
    vq.push_back('{0, 1,0,32'h20,4'hF,32'h0, 1,0,32'h24,4'hF,32'h0, 4'b0110,4'hF,6'b100000,8'h00,32'h10000008,32'h0});
    vq.push_back('{0, 0,0,32'h0,4'h0,32'h0, 0,0,32'h0,4'h0,32'h0, 4'b0000,4'h0,6'b010000,8'h00,32'h0,32'h10000009});
    // m1 character write
    vq.push_back('{0, 0,0,32'h0,4'h0,32'h0, 1,1,32'h00020000,4'h1,32'h41, 4'b0100,4'h0,6'b000000,8'h00,32'h0,32'h0});
    vq.push_back('{0, 0,0,32'h0,4'h0,32'h0, 0,0,32'h0,4'h0,32'h0, 4'b0000,4'h0,6'b000010,8'h41,32'h0,32'h0});
    // m0 halt write, sticky
    vq.push_back('{0, 1,1,32'h00020002,4'hF,32'h1, 0,0,32'h0,4'h0,32'h0, 4'b1000,4'h0,6'b000000,8'h41,32'h0,32'h0});
    vq.push_back('{0, 0,0,32'h0,4'h0,32'h0, 0,0,32'h0,4'h0,32'h0, 4'b0000,4'h0,6'b000001,8'h41,32'h0,32'h0});
    // out-of-range read
    vq.push_back('{0, 1,0,32'h00100000,4'hF,32'h0, 0,0,32'h0,4'h0,32'h0, 4'b1000,4'h0,6'b000001,8'h41,32'h0,32'h0});
    vq.push_back('{0, 0,0,32'h0,4'h0,32'h0, 0,0,32'h0,4'h0,32'h0, 4'b0000,4'h0,6'b101001,8'h41,32'h0,32'h0});
    // MMIO read (rvalid, no err), then out-of-range write (err, no rvalid)
    vq.push_back('{0, 0,0,32'h0,4'h0,32'h0, 1,0,32'h00020002,4'hF,32'h0, 4'b0100,4'h0,6'b000001,8'h41,32'h0,32'h0});
    vq.push_back('{0, 1,1,32'h00100000,4'hF,32'h12345678, 0,0,32'h0,4'h0,32'h0, 4'b1000,4'h0,6'b010001,8'h41,32'h0,32'h0});
    vq.push_back('{0, 0,0,32'h0,4'h0,32'h0, 0,0,32'h0,4'h0,32'h0, 4'b0000,4'h0,6'b001001,8'h41,32'h0,32'h0});
    // read granted with reset at the same edge: response dropped, halt/char cleared
    vq.push_back('{1, 1,0,32'h10,4'hF,32'h0, 0,0,32'h0,4'h0,32'h0, 4'b1010,4'hF,6'b000001,8'h41,32'h0,32'h0});
    vq.push_back('{0, 1,0,32'h10,4'hF,32'h0, 1,0,32'h24,4'hF,32'h0, 4'b1010,4'hF,6'b000000,8'h00,32'h0,32'h0});
    vq.push_back('{0, 0,0,32'h0,4'h0,32'h0, 0,0,32'h0,4'h0,32'h0, 4'b0000,4'h0,6'b100000,8'h00,32'hDEADBEEF,32'h0});
    // sel = 0 write leaves the word unchanged
    vq.push_back('{0, 0,0,32'h0,4'h0,32'h0, 1,1,32'h10,4'h0,32'hFFFFFFFF, 4'b0111,4'h0,6'b000000,8'h00,32'h0,32'h0});
    vq.push_back('{0, 0,0,32'h0,4'h0,32'h0, 1,0,32'h10,4'hF,32'h0, 4'b0110,4'hF,6'b000000,8'h00,32'h0,32'h0});
    vq.push_back('{0, 0,0,32'h0,4'h0,32'h0, 0,0,32'h0,4'h0,32'h0, 4'b0000,4'h0,6'b010000,8'h00,32'h0,32'hDEADBEEF});

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      check($sformatf("vec %0d", i),
            {42'd0, m0_gnt, m1_gnt, ram_ce, ram_we, ram_sel,
             m0_rvalid, m1_rvalid, m0_err, m1_err, char_valid, sim_halt,
             char_out, m0_rdata, m1_rdata},
            {42'd0, vq[i].e_ctl, vq[i].e_sel, vq[i].e_rsp, vq[i].e_ch,
             vq[i].e_rd0, vq[i].e_rd1});
    end

    // Streaming: both read for 6 cycles after reset; grants alternate from m0
    begin
      vec_t idle;
      logic exp0;
      logic [1:0] prev_g;
      idle = '{1, 0,0,32'h0,4'h0,32'h0, 0,0,32'h0,4'h0,32'h0, 4'h0,4'h0,6'h0,8'h0,32'h0,32'h0};
      @(negedge clk);
      drive(idle);
      exp0   = 1'b1;
      prev_g = 2'b00;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        rst = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h20; m0_sel = 4'hF;
        m1_req = 1; m1_we = 0; m1_addr = 32'h24; m1_sel = 4'hF;
        #1;
        check($sformatf("rr gnt %0d", c), {126'd0, m0_gnt, m1_gnt}, {126'd0, exp0, ~exp0});
        check($sformatf("rr rvalid %0d", c), {126'd0, m0_rvalid, m1_rvalid}, {126'd0, prev_g});
        check($sformatf("rr no-collide %0d", c), {127'd0, m0_rvalid & m1_rvalid}, 128'd0);
        prev_g = {exp0, ~exp0};
        exp0   = ~exp0;
      end
      @(negedge clk);
      idle.rst = 0;
      drive(idle);
      #1;
      check("rr last rvalid", {126'd0, m0_rvalid, m1_rvalid}, {126'd0, prev_g});
      check("rr last rdata", {64'd0, m0_rdata, m1_rdata}, {64'd0, 32'h0, 32'h10000009});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ram_port_arbiter
`default_nettype wire
